rvseed_ifu_prefetch: RTL and testbench

- Parametrised next-generation instruction fetch front end for the RVSEED core.
- Acts as an AXI4 read master that fetches sequential instruction words in INCR bursts into an instruction FIFO.
- Presents instructions to the decode stage over a valid/ready handshake.
- Supports PC redirect (branch/jump) with FIFO flush and in-flight burst drain.

---
 rtl/rvseed_ifu_prefetch.sv | 236 +++++++++++++++++++++++
 tb/tb_rvseed_ifu_prefetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rvseed_ifu_prefetch.sv
// rvseed_ifu_prefetch: AXI4 read-master instruction prefetcher for the RVSEED core.
// Sequential words are fetched in INCR bursts that never cross a 4KB page.
// FIFO credits are reserved before each AR is issued, so the FIFO cannot overflow.
// Entries are handed to decode first-word-fall-through over a valid/ready handshake.
// A redirect flushes the FIFO and drains any in-flight burst before fetch resumes.
// Optional: define IFU_PREFETCH_PERF_CNT_EN to add the perf_fetch_cnt/perf_drop_cnt ports.
module rvseed_ifu_prefetch #(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter int              ID_W       = 4,
    parameter int              AXI_ID     = 0,
    parameter int              FIFO_DEPTH = 8,
    parameter int              BURST_LEN  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ifu_mst_arvalid,
    input  logic              ifu_mst_arready,
    output logic [ID_W-1:0]   ifu_mst_arid,
    output logic [ADDR_W-1:0] ifu_mst_araddr,
    output logic [7:0]        ifu_mst_arlen,
    output logic [2:0]        ifu_mst_arsize,
    output logic [1:0]        ifu_mst_arburst,
    output logic              ifu_mst_arlock,
    output logic [3:0]        ifu_mst_arcache,
    output logic [2:0]        ifu_mst_arprot,
    output logic [3:0]        ifu_mst_arqos,
    output logic [3:0]        ifu_mst_arregion,
    input  logic              ifu_mst_rvalid,
    output logic              ifu_mst_rready,
    input  logic [ID_W-1:0]   ifu_mst_rid,
    input  logic [DATA_W-1:0] ifu_mst_rdata,
    input  logic [1:0]        ifu_mst_rresp,
    input  logic              ifu_mst_rlast,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err
`ifdef IFU_PREFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_drop_cnt
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DRAIN = 2'd3} state_t;

    state_t             state_r;
    logic [ADDR_W-1:0]  fetch_pc_r;
    logic [ADDR_W-1:0]  araddr_r;
    logic [7:0]         arlen_r;
    logic               arvalid_r;
    logic               rready_r;
    logic               abort_r;     // redirect seen while AR was still waiting
    logic [ADDR_W-1:0]  wr_pc_r;     // PC of the next beat to be written

    logic [DATA_W-1:0]  mem_data_r [FIFO_DEPTH];
    logic [ADDR_W-1:0]  mem_pc_r   [FIFO_DEPTH];
    logic               mem_err_r  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_r;
    logic [PTR_W-1:0]   rptr_r;
    logic [CNT_W-1:0]   count_r;

    logic [10:0]        words_to_bnd_s;
    logic [10:0]        beats_s;
    logic [CNT_W-1:0]   free_s;
    logic               start_s;
    logic               ar_fire_s;
    logic               r_fire_s;
    logic               push_s;
    logic               pop_s;
    logic               drop_beat_s;
    logic [ADDR_W-1:0]  burst_bytes_s;
    logic               unused_s;

    assign words_to_bnd_s = 11'd1024 - {1'b0, fetch_pc_r[11:2]};
    assign beats_s        = (words_to_bnd_s < 11'(BURST_LEN)) ? words_to_bnd_s : 11'(BURST_LEN);
    assign free_s         = CNT_W'(FIFO_DEPTH) - count_r;
    assign start_s        = (state_r == IDLE) && enable && !redirect_valid && (11'(free_s) >= beats_s);
    assign ar_fire_s      = arvalid_r && ifu_mst_arready;
    assign r_fire_s       = rready_r && ifu_mst_rvalid;
    // A beat arriving in the redirect cycle belongs to the old stream: drop it.
    assign push_s         = r_fire_s && (state_r == DATA) && !redirect_valid;
    assign pop_s          = inst_valid && inst_ready && !redirect_valid;
    assign drop_beat_s    = r_fire_s && !push_s;
    assign burst_bytes_s  = ADDR_W'({(9'(arlen_r) + 9'd1), 2'b00});
    assign unused_s       = ^ifu_mst_rid;

    assign ifu_mst_arvalid  = arvalid_r;
    assign ifu_mst_araddr   = araddr_r;
    assign ifu_mst_arlen    = arlen_r;
    assign ifu_mst_arid     = ID_W'(AXI_ID);
    assign ifu_mst_arsize   = 3'($clog2(DATA_W / 8));
    assign ifu_mst_arburst  = 2'b01;
    assign ifu_mst_arlock   = 1'b0;
    assign ifu_mst_arcache  = 4'b0010;
    assign ifu_mst_arprot   = 3'b100;
    assign ifu_mst_arqos    = 4'b0000;
    assign ifu_mst_arregion = 4'b0000;
    assign ifu_mst_rready   = rready_r;

    assign inst_valid = (count_r != CNT_W'(0));
    assign inst       = mem_data_r[rptr_r];
    assign inst_pc    = mem_pc_r[rptr_r];
    assign inst_err   = mem_err_r[rptr_r];

    // Fetch FSM: AR issue, R acceptance/drain, fetch PC tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            araddr_r   <= '0;
            arlen_r    <= 8'd0;
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
            abort_r    <= 1'b0;
            wr_pc_r    <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc_r <= redirect_pc;
            end
            if (push_s) begin
                wr_pc_r <= wr_pc_r + ADDR_W'(32'd4);
            end
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r   <= ADDR;
                        arvalid_r <= 1'b1;
                        araddr_r  <= fetch_pc_r;
                        arlen_r   <= 8'(beats_s - 11'd1);
                        abort_r   <= 1'b0;
                    end
                end
                ADDR: begin
                    if (ar_fire_s) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        wr_pc_r   <= araddr_r;
                        if (redirect_valid || abort_r) begin
                            state_r <= DRAIN;
                        end else begin
                            state_r    <= DATA;
                            fetch_pc_r <= fetch_pc_r + burst_bytes_s;
                        end
                    end else if (redirect_valid) begin
                        abort_r <= 1'b1;
                    end
                end
                DATA: begin
                    if (r_fire_s && ifu_mst_rlast) begin
                        state_r  <= IDLE;
                        rready_r <= 1'b0;
                    end else if (redirect_valid) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_fire_s && ifu_mst_rlast) begin
                        state_r  <= IDLE;
                        rready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                end
            endcase
        end
    end

    // Instruction FIFO: push from R channel, pop to decode, flush on redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_r[i] <= '0;
                mem_pc_r[i]   <= '0;
                mem_err_r[i]  <= 1'b0;
            end
        end else if (redirect_valid) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                mem_data_r[wptr_r] <= ifu_mst_rdata;
                mem_pc_r[wptr_r]   <= wr_pc_r;
                mem_err_r[wptr_r]  <= (ifu_mst_rresp != 2'b00);
                wptr_r             <= wptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef IFU_PREFETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    logic [31:0] drop_inc_s;
    assign drop_inc_s = (redirect_valid ? 32'(count_r) : 32'd0) + (drop_beat_s ? 32'd1 : 32'd0);

    // Saturating event counters for accepted and discarded beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_drop_cnt  <= 32'd0;
        end else begin
            perf_fetch_cnt <= sat_add(perf_fetch_cnt, push_s ? 32'd1 : 32'd0);
            perf_drop_cnt  <= sat_add(perf_drop_cnt, drop_inc_s);
        end
    end
`endif

endmodule

// File: tb/tb_rvseed_ifu_prefetch.sv
// Directed self-checking bench for rvseed_ifu_prefetch (default parameters).
module tb_rvseed_ifu_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        arvalid, arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos, arregion;
    logic        rvalid, rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        inst_err;
`ifdef IFU_PREFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rvseed_ifu_prefetch dut (
        .clk(clk), .rst(rst), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifu_mst_arvalid(arvalid), .ifu_mst_arready(arready), .ifu_mst_arid(arid),
        .ifu_mst_araddr(araddr), .ifu_mst_arlen(arlen), .ifu_mst_arsize(arsize),
        .ifu_mst_arburst(arburst), .ifu_mst_arlock(arlock), .ifu_mst_arcache(arcache),
        .ifu_mst_arprot(arprot), .ifu_mst_arqos(arqos), .ifu_mst_arregion(arregion),
        .ifu_mst_rvalid(rvalid), .ifu_mst_rready(rready), .ifu_mst_rid(rid),
        .ifu_mst_rdata(rdata), .ifu_mst_rresp(rresp), .ifu_mst_rlast(rlast),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_err(inst_err)
`ifdef IFU_PREFETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait (bounded) for an AR request.
    task automatic wait_ar(input string tag);
        int n = 0;
        while (arvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_arvalid"}, 64'(arvalid), 64'd1);
    endtask

    // Check AR fields, hold arready low for delay cycles checking stability, then accept.
    task automatic do_ar(input string tag, input logic [31:0] addr, input logic [7:0] len, input int delay);
        wait_ar(tag);
        chk({tag, "_araddr"}, 64'(araddr), 64'(addr));
        chk({tag, "_arlen"}, 64'(arlen), 64'(len));
        for (int i = 0; i < delay; i++) begin
            tick();
            chk({tag, "_hold_valid"}, 64'(arvalid), 64'd1);
            chk({tag, "_hold_addr"}, 64'(araddr), 64'(addr));
            chk({tag, "_hold_len"}, 64'(arlen), 64'(len));
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk({tag, "_ar_done"}, 64'(arvalid), 64'd0);
    endtask

    task automatic send_beat(input string tag, input logic [31:0] d, input logic [1:0] resp, input logic last);
        chk({tag, "_rready"}, 64'(rready), 64'd1);
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        rlast  = last;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] d, input logic [31:0] pc, input logic err);
        chk({tag, "_valid"}, 64'(inst_valid), 64'd1);
        chk({tag, "_inst"}, 64'(inst), 64'(d));
        chk({tag, "_pc"}, 64'(inst_pc), 64'(pc));
        chk({tag, "_err"}, 64'(inst_err), 64'(err));
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        arready = 1'b0; rvalid = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00;
        rlast = 1'b0; inst_ready = 1'b0;
        tick(); tick();
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", 64'(inst_pc), 64'd0);
        chk("rst_inst_err", 64'(inst_err), 64'd0);
        rst = 1'b0;
        enable = 1'b1;

        // First burst from RESET_PC with constant AR attributes.
        wait_ar("b0");
        chk("arsize", 64'(arsize), 64'd2);
        chk("arburst", 64'(arburst), 64'd1);
        chk("arcache", 64'(arcache), 64'd2);
        chk("arprot", 64'(arprot), 64'd4);
        chk("arid", 64'(arid), 64'd0);
        chk("arlock_qos_region", 64'({arlock, arqos, arregion}), 64'd0);
        do_ar("b0", 32'h0, 8'd3, 0);
        send_beat("b0_1", 32'h11, 2'b00, 1'b0);
        chk("latency_valid", 64'(inst_valid), 64'd1);
        chk("latency_inst", 64'(inst), 64'h11);
        send_beat("b0_2", 32'h22, 2'b00, 1'b0);
        send_beat("b0_3", 32'h33, 2'b00, 1'b0);
        send_beat("b0_4", 32'h44, 2'b00, 1'b1);

        // Second burst fits in the remaining 4 credits; then the FIFO is full.
        do_ar("b1", 32'h10, 8'd3, 0);
        send_beat("b1_1", 32'h55, 2'b00, 1'b0);
        send_beat("b1_2", 32'h66, 2'b00, 1'b0);
        send_beat("b1_3", 32'h77, 2'b00, 1'b0);
        send_beat("b1_4", 32'h88, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("full_no_ar", 64'(arvalid), 64'd0);
        end
        pop_chk("p0", 32'h11, 32'h0, 1'b0);
        pop_chk("p1", 32'h22, 32'h4, 1'b0);
        pop_chk("p2", 32'h33, 32'h8, 1'b0);
        chk("three_pops_no_ar", 64'(arvalid), 64'd0);
        pop_chk("p3", 32'h44, 32'hC, 1'b0);
        chk("four_pops_ar_next", 64'(arvalid), 64'd0);
        tick();
        chk("third_ar_valid", 64'(arvalid), 64'd1);
        chk("third_ar_addr", 64'(araddr), 64'h20);
        pop_chk("p4", 32'h55, 32'h10, 1'b0);
        pop_chk("p5", 32'h66, 32'h14, 1'b0);
        chk("ar_wait_addr", 64'(araddr), 64'h20);
        chk("ar_wait_len", 64'(arlen), 64'd3);

        // Redirect while AR waits, with a simultaneous pop: flush wins, AR held, burst drained.
        redirect_valid = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        chk("flush_inst_valid", 64'(inst_valid), 64'd0);
        chk("redir_ar_held", 64'(arvalid), 64'd1);
        chk("redir_ar_addr", 64'(araddr), 64'h20);
        tick();
        chk("redir_ar_held2", 64'(arvalid), 64'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("drain_no_ar", 64'(arvalid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            send_beat("drain", 32'hD1 + 32'(i), 2'b00, (i == 3) ? 1'b1 : 1'b0);
            chk("drain_no_valid", 64'(inst_valid), 64'd0);
        end

        // Fetch resumes at redirect target; redirect after beat 1 drops the rest.
        do_ar("redir", 32'h200, 8'd3, 0);
        send_beat("a1", 32'hA1, 2'b00, 1'b0);
        chk("a1_valid", 64'(inst_valid), 64'd1);
        chk("a1_inst", 64'(inst), 64'hA1);
        chk("a1_pc", 64'(inst_pc), 64'h200);
        redirect_valid = 1'b1; redirect_pc = 32'hFF8;
        tick();
        redirect_valid = 1'b0;
        chk("mid_flush_valid", 64'(inst_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            send_beat("a_drop", 32'hA2 + 32'(i), 2'b00, (i == 2) ? 1'b1 : 1'b0);
            chk("a_drop_no_valid", 64'(inst_valid), 64'd0);
        end

        // 4KB boundary: two words left at 0xFF8; beat 2 carries an error response.
        do_ar("bnd", 32'hFF8, 8'd1, 0);
        send_beat("bnd_1", 32'hB1, 2'b00, 1'b0);
        send_beat("bnd_2", 32'hB2, 2'b10, 1'b1);
        do_ar("wrap", 32'h1000, 8'd3, 5);
        pop_chk("pb0", 32'hB1, 32'hFF8, 1'b0);
        pop_chk("pb1", 32'hB2, 32'hFFC, 1'b1);
        send_beat("c1", 32'hC1, 2'b00, 1'b0);
        chk("c1_valid", 64'(inst_valid), 64'd1);
        chk("c1_pc", 64'(inst_pc), 64'h1000);
`ifdef IFU_PREFETCH_PERF_CNT_EN
        chk("perf_fetch", 64'(perf_fetch_cnt), 64'd12);
        chk("perf_drop", 64'(perf_drop_cnt), 64'd10);
`endif

        // Asynchronous reset mid-burst clears outputs without waiting for a clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rready", 64'(rready), 64'd0);
        chk("arst_arvalid", 64'(arvalid), 64'd0);
        chk("arst_inst_valid", 64'(inst_valid), 64'd0);
        chk("arst_inst", 64'(inst), 64'd0);
`ifdef IFU_PREFETCH_PERF_CNT_EN
        chk("arst_perf_fetch", 64'(perf_fetch_cnt), 64'd0);
        chk("arst_perf_drop", 64'(perf_drop_cnt), 64'd0);
`endif
        tick();
        rst = 1'b0;
        wait_ar("post_rst");
        chk("post_rst_addr", 64'(araddr), 64'h0);
        chk("post_rst_len", 64'(arlen), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
